// File: rtl/jtag_debug_cmd_bridge_if.sv
// Record stream from the JTAG command bridge to the debug core.
// The master presents one queued update record; the slave accepts it with ready.
interface jtag_debug_cmd_bridge_if #(
    parameter int IR_WIDTH   = 2,
    parameter int DATA_WIDTH = 38
);
    logic                       valid;
    logic                       ready;
    logic                       is_ir;
    logic [IR_WIDTH-1:0]        ir;
    logic [(1<<IR_WIDTH)-1:0]   ch;
    logic [DATA_WIDTH-1:0]      data;

    modport master (
        output valid, is_ir, ir, ch, data,
        input  ready
    );

    modport slave (
        input  valid, is_ir, ir, ch, data,
        output ready
    );
endinterface

// File: rtl/jtag_debug_cmd_bridge.sv
// System-clock side of the virtual-JTAG debug bridge: strobe sync,
// record FIFO with first-word-fall-through output and drop accounting.
module jtag_debug_cmd_bridge #(
    parameter int IR_WIDTH    = 2,
    parameter int DATA_WIDTH  = 38,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [IR_WIDTH-1:0]         i_ir_in,
    input  logic [DATA_WIDTH-1:0]       i_sr,
    input  logic                        i_vs_udr,
    input  logic                        i_vs_uir,
    input  logic                        i_clr_drop,
    jtag_debug_cmd_bridge_if.master     o_out,
    output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
    output logic                        o_drop_sticky,
    output logic [7:0]                  o_drop_count
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CH  = 1 << IR_WIDTH;
    localparam int RW  = 1 + IR_WIDTH + DATA_WIDTH;
    localparam int ARM = SYNC_STAGES + 1;

    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic                   r_udr_hist;
    logic                   r_uir_hist;
    logic [2:0]             r_arm_cnt;
    logic [AW:0]            r_wr_ptr;
    logic [AW:0]            r_rd_ptr;
    logic [RW-1:0]          r_mem [FIFO_DEPTH];
    logic                   r_drop_sticky;
    logic [7:0]             r_drop_count;

    logic                   w_armed;
    logic                   w_udr_rise;
    logic                   w_uir_rise;
    logic [AW:0]            w_level;
    logic                   w_valid;
    logic                   w_full;
    logic                   w_pop;
    logic                   w_push_req;
    logic                   w_push_ok;
    logic [RW-1:0]          w_rec;
    logic [RW-1:0]          w_head;
    logic [1:0]             w_drops;
    logic [8:0]             w_cnt_sum;
    logic [7:0]             w_cnt_next;
    logic                   w_sticky_next;

    // Strobe synchronisers, edge history and post-reset arming counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_udr_sync <= '0;
            r_uir_sync <= '0;
            r_udr_hist <= 1'b0;
            r_uir_hist <= 1'b0;
            r_arm_cnt  <= 3'd0;
        end else begin
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], i_vs_udr};
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], i_vs_uir};
            r_udr_hist <= r_udr_sync[SYNC_STAGES-1];
            r_uir_hist <= r_uir_sync[SYNC_STAGES-1];
            if (r_arm_cnt != 3'(ARM))
                r_arm_cnt <= r_arm_cnt + 3'd1;
        end
    end

    assign w_armed    = (r_arm_cnt == 3'(ARM));
    assign w_udr_rise = w_armed & r_udr_sync[SYNC_STAGES-1] & ~r_udr_hist;
    assign w_uir_rise = w_armed & r_uir_sync[SYNC_STAGES-1] & ~r_uir_hist;

    assign w_level    = r_wr_ptr - r_rd_ptr;
    assign w_valid    = (r_wr_ptr != r_rd_ptr);
    assign w_full     = (w_level == (AW+1)'(FIFO_DEPTH));
    assign w_pop      = w_valid & o_out.ready;
    assign w_push_req = w_udr_rise | w_uir_rise;
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_head     = r_mem[r_rd_ptr[AW-1:0]];

    // Record selection (DR wins a tie) and drop/count next-state
    always_comb begin
        w_rec = {1'b1, i_ir_in, {DATA_WIDTH{1'b0}}};
        if (w_udr_rise)
            w_rec = {1'b0, i_ir_in, i_sr};
        w_drops = 2'd0;
        if (w_udr_rise & w_uir_rise)
            w_drops = w_drops + 2'd1;
        if (w_push_req & ~w_push_ok)
            w_drops = w_drops + 2'd1;
        w_cnt_sum = {1'b0, (i_clr_drop ? 8'd0 : r_drop_count)} + {7'd0, w_drops};
        w_cnt_next = w_cnt_sum[8] ? 8'hFF : w_cnt_sum[7:0];
        w_sticky_next = (~i_clr_drop & r_drop_sticky) | (w_drops != 2'd0);
    end

    // FIFO pointers and drop accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_drop_sticky <= 1'b0;
            r_drop_count  <= 8'd0;
        end else begin
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            r_drop_sticky <= w_sticky_next;
            r_drop_count  <= w_cnt_next;
        end
    end

    // Record storage; contents are only visible through a valid head
    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wr_ptr[AW-1:0]] <= w_rec;
    end

    assign o_out.valid = w_valid;
    assign o_out.is_ir = w_valid & w_head[RW-1];
    assign o_out.ir    = w_valid ? w_head[RW-2 -: IR_WIDTH] : '0;
    assign o_out.data  = w_valid ? w_head[DATA_WIDTH-1:0] : '0;
    assign o_out.ch    = (w_valid & ~w_head[RW-1])
                       ? ({{(CH-1){1'b0}}, 1'b1} << w_head[RW-2 -: IR_WIDTH])
                       : '0;
    assign o_fifo_level  = w_level;
    assign o_drop_sticky = r_drop_sticky;
    assign o_drop_count  = r_drop_count;
endmodule

// File: doc/jtag_debug_cmd_bridge.md
Name: jtag_debug_cmd_bridge

Overview:
- Parametrised successor to the Nios debug-slave system-clock side.
- Takes quasi-static virtual-JTAG data (instruction register, shift register) and the UDR/UIR update strobes from the TCK domain.
- Synchronises the strobes into clk and queues each update as a record in a small FIFO.
- Presents records to the debug core over a valid/ready stream, with per-channel one-hot decode and sticky drop accounting.
- Generalises the fixed 2-bit IR / 38-bit data / single-shot pulse scheme to configurable widths, buffering and back-pressure.

Parameters:
IR_WIDTH, 2, instruction register width; channel count is 2**IR_WIDTH
DATA_WIDTH, 38, shift-register / record data width
SYNC_STAGES, 2, synchroniser flops per strobe (legal range 2..4)
FIFO_DEPTH, 4, record FIFO entries (power of two, 2..16)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ir_in  in  IR_WIDTH  virtual IR value, stable while strobes are active
sr  in  DATA_WIDTH  shift-register contents, stable while vs_udr is high
vs_udr  in  1  update-DR strobe, TCK domain, level
vs_uir  in  1  update-IR strobe, TCK domain, level
out_valid  out  1  head record available
out_ready  in  1  consumer accepts head record
out_is_ir  out  1  1 = IR-update record, 0 = DR-update record
out_ir  out  IR_WIDTH  IR captured with the record
out_ch  out  2**IR_WIDTH  one-hot decode of out_ir for DR records; all zeros for IR records
out_data  out  DATA_WIDTH  sr captured for DR records; zero for IR records
fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy
drop_sticky  out  1  set on any lost record
drop_count  out  8  saturating count of lost records
clr_drop  in  1  clears drop_sticky and drop_count

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset:
  - Clears synchroniser and edge registers, FIFO pointers, drop_sticky and drop_count.
  - All outputs read 0 in the cycle after the reset edge.
  - Reset mid-operation discards every queued record; no partial record survives.
- Arming:
  - After reset deasserts, edge detection is masked for SYNC_STAGES+1 cycles while the chains fill.
  - A strobe held high across reset release therefore produces no record.
- Synchronisation:
  - Each strobe passes through SYNC_STAGES flops plus one history flop.
  - The rise pulse is sync_out & ~history; it lasts one clk cycle per strobe rising edge.
  - Falling edges are ignored.
- Capture: ir_in and sr are sampled directly (not synchronised) on the clk edge that ends the pulse cycle.
- Latency: if vs_udr is first sampled high at edge 0, the record is written at edge SYNC_STAGES and out_valid is high after that edge (with an empty FIFO).
- Simultaneous DR and IR pulses in the same cycle:
  - The DR record is pushed.
  - The IR record is lost and counts as one drop.
- FIFO:
  - First-word-fall-through; out_* reflect the head whenever out_valid = 1.
  - out_* are stable while out_valid & ~out_ready.
  - Pop occurs on out_valid & out_ready.
  - A push into a full FIFO is accepted only if a pop happens in the same cycle; otherwise the new record is dropped and the head is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; fifo_level is the occupancy after the edge.
  - An empty FIFO with a push shows out_valid the next cycle; there is no combinational bypass.
- Drop accounting:
  - Each lost record sets drop_sticky and increments drop_count, which saturates at 255.
  - clr_drop in the same cycle as a drop: the clear wins, and the new drop re-sets the sticky and yields count 1 on that edge.
- out_ready while empty has no effect; the level never underflows.

Test Plan:
- SYNC_STAGES=2: ir_in=2'b01, sr=38'h15_DEAD_BEEF, pulse vs_udr high for 3 cycles -> exactly one record. out_valid rises 2 edges after the first high sample, out_is_ir=0, out_ch=4'b0010, out_data=38'h15_DEAD_BEEF.
- vs_uir pulse with ir_in=2'b11 -> out_is_ir=1, out_ir=2'b11, out_ch=0, out_data=0.
- Hold out_ready=0 and send 6 DR updates with FIFO_DEPTH=4 -> fifo_level=4, drop_count=2, drop_sticky=1. Draining yields the first 4 sr values in order. clr_drop then returns both counters to 0.
- Full FIFO with out_ready=1 in the push cycle -> push accepted, level stays 4, no drop.
- vs_udr and vs_uir rising in the same sampled cycle -> one DR record, drop_count=1.
- Assert reset for 1 cycle with 3 records queued and vs_udr held high -> level=0, out_valid=0, and no record is produced after release until vs_udr falls and rises again.
